// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Contents:
//   - opcode constants
//   - ALUOp, PCSource and ALUSrcB encodings
//   - the 4-bit FSM state enum (FETCH = 0)
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_e;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multi-cycle control unit and its datapath.
//   master: control unit (consumes OpCode/mem_ready, drives every enable/select)
//   slave : datapath / memory side
interface mips_multicycle_control_if;
  logic [5:0] OpCode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemToReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;

  modport master (
    input  OpCode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg,
           IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp
  );

  modport slave (
    output OpCode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg,
           IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp
  );
endinterface

// File: rtl/mips_perf_counter.sv
// Free-running wrap-around event counter.
// Ports:
//   clk     - rising-edge clock
//   clear_n - synchronous active-low clear
//   enable  - count one event this cycle
//   count   - current value (wraps modulo 2^W)
module mips_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         enable,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (enable) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback over a shared-memory, single-ALU datapath.
// Ports:
//   clk, reset  - clock and synchronous active-low reset
//   bus         - OpCode/mem_ready in, all datapath enables and selects out
//   state       - current state encoding (debug)
//   illegal_op  - sticky unsupported-opcode flag, cleared by reset only
//   cycle_count - cycles with reset released
//   instr_count - completed instructions
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int COUNT_W      = 32,
  parameter bit SUPPORT_JUMP = 1'b1,
  parameter bit SUPPORT_ADDI = 1'b1,
  parameter bit MEM_WAIT     = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_control_if.master bus,
  output logic [3:0]             state,
  output logic                   illegal_op,
  output logic [COUNT_W-1:0]     cycle_count,
  output logic [COUNT_W-1:0]     instr_count
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   mem_rdy;
  logic   instr_done;

  // Without wait-state support every memory access completes in one cycle.
  assign mem_rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    instr_done = 1'b0;
    case (state_q)
      FETCH:    if (mem_rdy) state_d = DECODE;
      DECODE: begin
        case (bus.OpCode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J: begin
            if (SUPPORT_JUMP) state_d = JUMP;
            else begin
              state_d   = FETCH;
              illegal_d = 1'b1;
            end
          end
          OP_ADDI: begin
            if (SUPPORT_ADDI) state_d = ADDI_EXEC;
            else begin
              state_d   = FETCH;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Only lw/sw reach MEM_ADDR, so anything but lw is a store.
      MEM_ADDR:  state_d = (bus.OpCode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_rdy) state_d = MEM_WB;
      MEM_WRITE: begin
        if (mem_rdy) begin
          state_d    = FETCH;
          instr_done = 1'b1;
        end
      end
      EXECUTE:   state_d = ALU_WB;
      ADDI_EXEC: state_d = ADDI_WB;
      MEM_WB, ALU_WB, BRANCH, JUMP, ADDI_WB: begin
        state_d    = FETCH;
        instr_done = 1'b1;
      end
      default:   state_d = FETCH;
    endcase
  end

  // Moore outputs; everything is held at 0 while reset is asserted so the
  // PC and memory cannot be written during reset.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.PCSource    = PCSRC_ALU;
    bus.ALUSrcB     = SRCB_REG;
    bus.ALUOp       = ALUOP_ADD;
    if (reset) begin
      case (state_q)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = SRCB_FOUR;
          bus.IRWrite = mem_rdy;
          bus.PCWrite = mem_rdy;
        end
        DECODE:    bus.ALUSrcB = SRCB_IMM_SH2;
        MEM_ADDR, ADDI_EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        MEM_READ: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEM_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemToReg = 1'b1;
        end
        MEM_WRITE: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        EXECUTE: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALUOP_FUNCT;
        end
        ALU_WB: begin
          bus.RegDst   = 1'b1;
          bus.RegWrite = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = ALUOP_SUB;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = PCSRC_ALUOUT;
        end
        JUMP: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = PCSRC_JUMP;
        end
        ADDI_WB:   bus.RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;

  mips_perf_counter #(.W(COUNT_W)) u_cycle_counter (
    .clk     (clk),
    .clear_n (reset),
    .enable  (1'b1),
    .count   (cycle_count)
  );

  mips_perf_counter #(.W(COUNT_W)) u_instr_counter (
    .clk     (clk),
    .clear_n (reset),
    .enable  (instr_done),
    .count   (instr_count)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control. Two instances share stimulus:
// dut_a uses defaults, dut_b has COUNT_W=4 and SUPPORT_JUMP=0. Each vector
// pushes the expected state/controls/counters for one DUT; a monitor pops and
// compares on the falling edge.
module tb_mips_multicycle_control;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic [5:0] op    = 6'h00;
  logic       mr    = 1'b1;

  mips_multicycle_control_if if_a();
  mips_multicycle_control_if if_b();
  assign if_a.OpCode = op;
  assign if_a.mem_ready = mr;
  assign if_b.OpCode = op;
  assign if_b.mem_ready = mr;

  logic [3:0]  st_a, st_b;
  logic        ill_a, ill_b;
  logic [31:0] cc_a, ic_a;
  logic [3:0]  cc_b, ic_b;

  mips_multicycle_control dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .state(st_a),
    .illegal_op(ill_a), .cycle_count(cc_a), .instr_count(ic_a)
  );

  mips_multicycle_control #(.COUNT_W(4), .SUPPORT_JUMP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .state(st_b),
    .illegal_op(ill_b), .cycle_count(cc_b), .instr_count(ic_b)
  );

  typedef struct {
    bit          sel;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
    logic [31:0] ic;
    logic [31:0] cc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  bit         cur_sel = 1'b0;
  bit         prev_rst = 1'b0;
  logic [3:0] prev_st = 4'd0;
  int         exp_cc = 0, exp_ic = 0;
  bit         exp_ill = 1'b0;

  // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemToReg,IRWrite,
  //                ALUSrcA,RegWrite,RegDst,PCSource[1:0],ALUSrcB[1:0],ALUOp[1:0]}
  function automatic logic [15:0] exp_ctrl(logic [3:0] s, bit m, bit r);
    logic [15:0] c;
    c = 16'h0000;
    if (r) begin
      case (s)
        4'd0:  c = m ? 16'h9204 : 16'h1004;
        4'd1:  c = 16'h000C;
        4'd2:  c = 16'h0108;
        4'd3:  c = 16'h3000;
        4'd4:  c = 16'h0480;
        4'd5:  c = 16'h2800;
        4'd6:  c = 16'h0102;
        4'd7:  c = 16'h00C0;
        4'd8:  c = 16'h4111;
        4'd9:  c = 16'h8020;
        4'd10: c = 16'h0108;
        4'd11: c = 16'h0080;
        default: c = 16'h0000;
      endcase
    end
    return c;
  endfunction

  function automatic logic [15:0] pack_ctrl(bit sel);
    if (sel)
      return {if_b.PCWrite, if_b.PCWriteCond, if_b.IorD, if_b.MemRead, if_b.MemWrite,
              if_b.MemToReg, if_b.IRWrite, if_b.ALUSrcA, if_b.RegWrite, if_b.RegDst,
              if_b.PCSource, if_b.ALUSrcB, if_b.ALUOp};
    return {if_a.PCWrite, if_a.PCWriteCond, if_a.IorD, if_a.MemRead, if_a.MemWrite,
            if_a.MemToReg, if_a.IRWrite, if_a.ALUSrcA, if_a.RegWrite, if_a.RegDst,
            if_a.PCSource, if_a.ALUSrcB, if_a.ALUOp};
  endfunction

  // One clock cycle: inputs applied just after the edge, expectation pushed.
  task automatic step(input bit r, input logic [5:0] o, input bit m, input logic [3:0] es);
    exp_t e;
    @(posedge clk);
    #1;
    if (!prev_rst) begin
      exp_cc = 0; exp_ic = 0; exp_ill = 1'b0;
    end else begin
      exp_cc++;
      if (es == 4'd0 && prev_st inside {4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd11}) exp_ic++;
      if (es == 4'd0 && prev_st == 4'd1) exp_ill = 1'b1;
    end
    reset = r; op = o; mr = m;
    e.sel = cur_sel; e.st = es; e.ctrl = exp_ctrl(es, m, r);
    e.ill = exp_ill; e.ic = exp_ic; e.cc = exp_cc;
    if (cur_sel) begin
      e.ic = e.ic & 32'hF;
      e.cc = e.cc & 32'hF;
    end
    sb.push_back(e);
    prev_rst = r; prev_st = es;
  endtask

  // Assert reset without checking the first cycle (state before it is unknown),
  // then check n cycles held in reset.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b0; op = 6'h00; mr = 1'b1; prev_rst = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, 6'h00, 1'b1, 4'd0);
  endtask

  // Run an instruction with mem_ready=1; seq holds the state trace, LSB nibble first.
  task automatic instr(input logic [5:0] o, input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) step(1'b1, o, 1'b1, seq[4*i +: 4]);
  endtask

  // Monitor: every cycle's outputs are valid; compare one vector per falling edge.
  initial begin
    exp_t e;
    logic [3:0]  g_st;
    logic [15:0] g_ctrl;
    logic        g_ill;
    logic [31:0] g_ic, g_cc;
    bit          bad;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel) begin
          g_st = st_b; g_ill = ill_b; g_ic = {28'd0, ic_b}; g_cc = {28'd0, cc_b};
        end else begin
          g_st = st_a; g_ill = ill_a; g_ic = ic_a; g_cc = cc_a;
        end
        g_ctrl = pack_ctrl(e.sel);
        bad = 1'b0;
        if (g_st !== e.st) begin
          $display("FAIL vec %0d dut%0d state: got %0d want %0d", vectors, e.sel, g_st, e.st); bad = 1'b1;
        end
        if (g_ctrl !== e.ctrl) begin
          $display("FAIL vec %0d dut%0d ctrl: got %h want %h", vectors, e.sel, g_ctrl, e.ctrl); bad = 1'b1;
        end
        if (g_ill !== e.ill) begin
          $display("FAIL vec %0d dut%0d illegal_op: got %0b want %0b", vectors, e.sel, g_ill, e.ill); bad = 1'b1;
        end
        if (g_ic !== e.ic) begin
          $display("FAIL vec %0d dut%0d instr_count: got %0d want %0d", vectors, e.sel, g_ic, e.ic); bad = 1'b1;
        end
        if (g_cc !== e.cc) begin
          $display("FAIL vec %0d dut%0d cycle_count: got %0d want %0d", vectors, e.sel, g_cc, e.cc); bad = 1'b1;
        end
        $display("vec %0d dut%0d state=%0d ctrl=%h ill=%0b ic=%0d cc=%0d", vectors, e.sel,
                 g_st, g_ctrl, g_ill, g_ic, g_cc);
        vectors++;
        if (bad) miscompares++;
      end
    end
  end

  initial begin
    // ---- dut_a: reset, then lw, sw, R-type, beq, j, addi ----
    cur_sel = 1'b0;
    do_reset(3);
    instr(OP_LW,    32'h0004_3210, 5);
    instr(OP_SW,    32'h0000_5210, 4);
    instr(OP_RTYPE, 32'h0000_7610, 4);
    instr(OP_BEQ,   32'h0000_0810, 3);
    instr(OP_J,     32'h0000_0910, 3);
    instr(OP_ADDI,  32'h0000_BA10, 4);
    // lw with two wait cycles in MEM_READ (first FETCH shows ic=6, cc=23)
    step(1'b1, OP_LW, 1'b1, 4'd0);
    step(1'b1, OP_LW, 1'b1, 4'd1);
    step(1'b1, OP_LW, 1'b1, 4'd2);
    step(1'b1, OP_LW, 1'b0, 4'd3);
    step(1'b1, OP_LW, 1'b0, 4'd3);
    step(1'b1, OP_LW, 1'b1, 4'd3);
    step(1'b1, OP_LW, 1'b1, 4'd4);
    // FETCH waits: PCWrite/IRWrite held low until mem_ready
    step(1'b1, OP_RTYPE, 1'b0, 4'd0);
    step(1'b1, OP_RTYPE, 1'b0, 4'd0);
    step(1'b1, OP_RTYPE, 1'b1, 4'd0);
    step(1'b1, OP_RTYPE, 1'b1, 4'd1);
    step(1'b1, OP_RTYPE, 1'b1, 4'd6);
    step(1'b1, OP_RTYPE, 1'b1, 4'd7);
    // illegal opcode on dut_a
    instr(6'h3F, 32'h0000_0010, 2);
    // sw aborted by reset during a MEM_WRITE wait
    step(1'b1, OP_SW, 1'b1, 4'd0);
    step(1'b1, OP_SW, 1'b1, 4'd1);
    step(1'b1, OP_SW, 1'b1, 4'd2);
    step(1'b1, OP_SW, 1'b0, 4'd5);
    step(1'b0, OP_SW, 1'b0, 4'd5);
    step(1'b0, OP_SW, 1'b1, 4'd0);
    step(1'b1, 6'h00, 1'b1, 4'd0);

    // ---- dut_b: illegal 0x3F, disabled j, then counter wrap ----
    cur_sel = 1'b1;
    do_reset(3);
    instr(6'h3F, 32'h0000_0010, 2);
    instr(OP_J,  32'h0000_0010, 2);
    for (int i = 0; i < 17; i++) step(1'b1, 6'h00, 1'b0, 4'd0);

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", sb.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
